mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequencer for one CPU memory transaction through the MAR/MDR pair. It accepts a read or
//  write request from the control unit and pulses the MAR and MDR load enables. It drives the
//  MDR source select (read=1: Mdatain, read=0: BusMuxOut) and handshakes with a wait-state
//  memory. It sits between the control unit, the MAR/MDR registers and the RAM. Timeout guarded.
// PARAMETERS
//  TIMEOUT     16   max wait cycles for mem_ready before abort (>=1)
//  CNT_W       5    wait counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk         in   1  system clock, all state on posedge
//  clr         in   1  asynchronous active-low reset (negedge clr clears all state)
//  rd_req      in   1  read request; level, held by requester until done/err
//  wr_req      in   1  write request; level, held until done/err
//  mem_ready   in   1  memory completion strobe, sampled only in wait states
//  mar_enable  out  1  MAR load enable (BusMuxOut -> MAR)
//  mdr_enable  out  1  MDR load enable
//  mdr_read    out  1  MDR source select: 1 = Mdatain, 0 = BusMuxOut
//  mem_rd      out  1  memory read strobe
//  mem_wr      out  1  memory write strobe
//  busy        out  1  high in every state except IDLE
//  done        out  1  one-cycle completion pulse
//  err         out  1  one-cycle timeout pulse
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, all outputs 0. clr mid-transaction aborts immediately.
//  There is no done/err pulse; mem_rd/mem_wr drop asynchronously.
//  All outputs are registered-state decodes (Moore); no input-to-output combinational path.
//  States and transitions:
//   IDLE     : rd_req -> LD_MAR(op=RD); else wr_req -> LD_MAR(op=WR). Read wins if both.
//   LD_MAR   : mar_enable=1; op=RD -> RD_WAIT; op=WR -> WR_MDR. Counter cleared.
//   WR_MDR   : mdr_enable=1, mdr_read=0 (latch store data from bus) -> WR_WAIT.
//   RD_WAIT  : mem_rd=1; mem_ready -> RD_LATCH; else counter++.
//   WR_WAIT  : mem_wr=1; mem_ready -> DONE; else counter++.
//   Both wait states: counter==TIMEOUT-1 with mem_ready=0 -> ERR.
//   RD_LATCH : mdr_enable=1, mdr_read=1 (capture Mdatain) -> DONE.
//   DONE     : done=1 for one cycle -> IDLE.
//   ERR      : err=1 for one cycle -> IDLE. The MDR is not loaded on a read abort.
//  Op is latched on leaving IDLE. Request changes after acceptance are ignored.
//  mem_ready outside RD_WAIT/WR_WAIT is ignored. mem_ready on the timeout cycle wins over timeout.
//  Back-to-back requests: a request still high in the cycle after DONE/ERR (state IDLE) starts
//  a new transaction. The requester deasserts on done/err to avoid a repeat.
//  Zero-wait latency, counted from the IDLE sample cycle: done high on cycle +4 (read and write).
//  N-wait latency: +4+N. Timeout: err high on cycle +2+TIMEOUT.
//  mdr_read is 0 in every state except RD_LATCH.
// STRUCTURE
//  Shared include mem_ctrl_defs.vh holds state encoding localparams (3-bit, IDLE=0) and OP_RD/OP_WR.
//  A single sub-module, wait_timer (CNT_W counter with clear/inc/expired), is natural.
//  Everything else is one FSM in this file.
// TESTING
//  1 Read, zero wait: rd_req@c0, mem_ready high in RD_WAIT -> mar_enable@c1, mem_rd@c2,
//    mdr_enable&mdr_read@c3, done@c4, busy c1..c4.
//  2 Write, 3 waits: wr_req@c0, mem_ready on 4th WR_WAIT cycle -> mdr_enable&!mdr_read@c2,
//    mem_wr c3..c6, done@c7.
//  3 Timeout, TIMEOUT=16: read with mem_ready held 0 -> mem_rd for 16 cycles, err@c18,
//    no mdr_enable, IDLE@c19.
//  4 Simultaneous rd_req=wr_req=1 -> read sequence runs. wr_req still high after done ->
//    write starts the next cycle.
//  5 clr low during RD_WAIT -> all outputs 0 within the same cycle, no done/err.
//    After release, an idle cycle precedes any request acceptance.
//  6 Spurious mem_ready in IDLE/LD_MAR/WR_MDR -> no state skip. Latency is identical to scenario 1.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MAR/MDR memory access sequencer.
//   state_t : FSM state encoding. The type is 3 bits wide and IDLE is 0, so a cleared state
//             register means "no transaction in flight".
//   op_t    : operation latched when a request is accepted.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_MAR   = 3'd1,
    S_WR_MDR   = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_WR_WAIT  = 3'd4,
    S_RD_LATCH = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-state counter for the memory handshake.
//   clk     : system clock
//   clr     : asynchronous active-low reset
//   clear   : synchronous clear to 0 (takes priority over inc)
//   inc     : count one more unanswered wait cycle
//   expired : current count equals TIMEOUT-1, so this is the last wait cycle allowed
module mem_access_ctrl_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments so that every flop
  // samples the values from before the clock edge, regardless of block ordering.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer for one CPU memory transaction through the MAR/MDR pair.
// The control unit requests a read or a write. The sequencer loads the MAR, loads the MDR
// from the bus (write) or from memory (read), and handshakes with a wait-state memory under
// a timeout guard. All outputs decode the registered state only (Moore).
//   clk        : system clock
//   clr        : asynchronous active-low reset; aborts any transaction with no done/err
//   rd_req     : read request (level; held until done/err)
//   wr_req     : write request (level; held until done/err)
//   mem_ready  : memory completion strobe, looked at only in the wait states
//   mar_enable : MAR load enable
//   mdr_enable : MDR load enable
//   mdr_read   : MDR source select, 1 = Mdatain, 0 = BusMuxOut
//   mem_rd     : memory read strobe
//   mem_wr     : memory write strobe
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   err        : one-cycle timeout pulse
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic clr,
  input  logic rd_req,
  input  logic wr_req,
  input  logic mem_ready,
  output logic mar_enable,
  output logic mdr_enable,
  output logic mdr_read,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state, state_nxt;
  op_t    op, op_nxt;
  logic   timer_clear, timer_inc, timer_expired;

  mem_access_ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .clr     (clr),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      op    <= OP_RD;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
    end
  end

  // Next-state logic. The operation is captured only when leaving IDLE, so later changes
  // on the request lines cannot alter a transaction already in flight.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left one unassigned
    // would infer a latch.
    state_nxt   = state;
    op_nxt      = op;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        timer_clear = 1'b1;
        if (rd_req) begin
          op_nxt    = OP_RD;
          state_nxt = S_LD_MAR;
        end else if (wr_req) begin
          op_nxt    = OP_WR;
          state_nxt = S_LD_MAR;
        end
      end
      S_LD_MAR: begin
        timer_clear = 1'b1;
        state_nxt   = (op == OP_RD) ? S_RD_WAIT : S_WR_MDR;
      end
      S_WR_MDR:  state_nxt = S_WR_WAIT;
      // mem_ready is checked before the timeout, so a late answer on the final wait cycle
      // still completes the transaction.
      S_RD_WAIT: begin
        if (mem_ready)          state_nxt = S_RD_LATCH;
        else if (timer_expired) state_nxt = S_ERR;
        else                    timer_inc = 1'b1;
      end
      S_WR_WAIT: begin
        if (mem_ready)          state_nxt = S_DONE;
        else if (timer_expired) state_nxt = S_ERR;
        else                    timer_inc = 1'b1;
      end
      S_RD_LATCH: state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      S_ERR:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    mar_enable = 1'b0;
    mdr_enable = 1'b0;
    mdr_read   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_LD_MAR:   mar_enable = 1'b1;
      S_WR_MDR:   mdr_enable = 1'b1;
      S_RD_WAIT:  mem_rd     = 1'b1;
      S_WR_WAIT:  mem_wr     = 1'b1;
      S_RD_LATCH: begin
        mdr_enable = 1'b1;
        mdr_read   = 1'b1;
      end
      S_DONE:     done = 1'b1;
      S_ERR:      err  = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl.
// Per-cycle expectations come from a transaction-level model: the output sequence is built
// from the operation type and the number of wait cycles the memory takes.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic clk = 1'b0;
  logic clr, rd_req, wr_req, mem_ready;
  logic mar_enable, mdr_enable, mdr_read, mem_rd, mem_wr, busy, done, err;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .mem_ready  (mem_ready),
    .mar_enable (mar_enable),
    .mdr_enable (mdr_enable),
    .mdr_read   (mdr_read),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mar, mdr_en, mdr_rd, mem_rd, mem_wr, busy, done, err;
  } outs_t;

  outs_t act;
  assign act = {mar_enable, mdr_enable, mdr_read, mem_rd, mem_wr, busy, done, err};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  function automatic outs_t ov(input bit mar, mdr_en, mdr_rd, m_rd, m_wr, bsy, dn, er);
    outs_t o;
    o = {mar, mdr_en, mdr_rd, m_rd, m_wr, bsy, dn, er};
    return o;
  endfunction

  localparam outs_t O_IDLE = '0;

  // Apply inputs for one cycle just after the rising edge, then sample at the falling edge.
  task automatic tick(input bit rd, input bit wr, input bit rdy);
    @(posedge clk);
    #1;
    rd_req    = rd;
    wr_req    = wr;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  // Run one complete transaction, comparing every cycle with the model sequence.
  // n_wait < TIMEOUT: memory answers on wait cycle n_wait (0-based); otherwise it never does.
  task automatic run_txn(input string name, input bit rd, input bit wr, input int n_wait,
                         input int exp_lat, input bit exp_err, input bit use_table);
    outs_t q[$];
    bit    is_rd, ok;
    int    waits, start, last, seen;
    bit    seen_err;
    is_rd    = rd;
    ok       = (n_wait < TIMEOUT);
    waits    = ok ? n_wait + 1 : TIMEOUT;
    start    = is_rd ? 2 : 3;
    seen     = -1;
    seen_err = 1'b0;
    // Model: IDLE, MAR load, (write: MDR load from bus), wait strobes, then finish.
    q.push_back(O_IDLE);
    q.push_back(ov(1, 0, 0, 0, 0, 1, 0, 0));
    if (!is_rd) q.push_back(ov(0, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < waits; i++)
      q.push_back(is_rd ? ov(0, 0, 0, 1, 0, 1, 0, 0) : ov(0, 0, 0, 0, 1, 1, 0, 0));
    if (ok) begin
      if (is_rd) q.push_back(ov(0, 1, 1, 0, 0, 1, 0, 0));
      q.push_back(ov(0, 0, 0, 0, 0, 1, 1, 0));
    end else begin
      q.push_back(ov(0, 0, 0, 0, 0, 1, 0, 1));
    end
    last = q.size() - 1;
    q.push_back(O_IDLE);
    for (int t = 0; t < q.size(); t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        rd_req = rd;
        wr_req = wr;
      end else if (t < last) begin
        // Request changes after acceptance must be ignored.
        rd_req = 1'($urandom_range(0, 1));
        wr_req = 1'($urandom_range(0, 1));
      end else begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      if (t >= start && t < start + waits) mem_ready = ok && (t == start + n_wait);
      else                                 mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("%s c%0d outs", name, t), 32'(act), 32'(q[t]));
      if ((act.done || act.err) && seen < 0) begin
        seen     = t;
        seen_err = act.err;
      end
    end
    if (use_table) begin
      check($sformatf("%s latency", name), 32'(seen), 32'(exp_lat));
      check($sformatf("%s err_flag", name), 32'(seen_err), 32'(exp_err));
    end
  endtask

  typedef struct {
    string name;
    bit    rd;
    bit    wr;
    int    n_wait;
    int    exp_lat;
    bit    exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit rd, wr;
    int n, sel, seen;

    // Latencies count from the IDLE cycle that samples the request. A write spends one
    // extra cycle in WR_MDR before waiting, so its timeout lands one cycle later.
    vecs[0] = '{"rd_0wait",      1'b1, 1'b0, 0,           4,  1'b0};
    vecs[1] = '{"wr_0wait",      1'b0, 1'b1, 0,           4,  1'b0};
    vecs[2] = '{"wr_3wait",      1'b0, 1'b1, 3,           7,  1'b0};
    vecs[3] = '{"rd_5wait",      1'b1, 1'b0, 5,           9,  1'b0};
    vecs[4] = '{"rd_last_cycle", 1'b1, 1'b0, TIMEOUT - 1, 19, 1'b0};
    vecs[5] = '{"rd_timeout",    1'b1, 1'b0, TIMEOUT,     18, 1'b1};
    vecs[6] = '{"wr_timeout",    1'b0, 1'b1, TIMEOUT,     19, 1'b1};
    vecs[7] = '{"rd_wr_both",    1'b1, 1'b1, 0,           4,  1'b0};

    clr       = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    mem_ready = 1'b0;
    #2;
    check("reset outs", 32'(act), 32'(O_IDLE));
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("post-reset idle", 32'(act), 32'(O_IDLE));

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].n_wait,
              vecs[i].exp_lat, vecs[i].exp_err, 1'b1);

    // Back-to-back: read wins when both requests are high; wr_req held past done starts
    // a write on the cycle after the IDLE cycle.
    tick(1, 1, 1); check("b2b c0", 32'(act), 32'(O_IDLE));
    tick(1, 1, 1); check("b2b c1", 32'(act), 32'(ov(1, 0, 0, 0, 0, 1, 0, 0)));
    tick(1, 1, 1); check("b2b c2", 32'(act), 32'(ov(0, 0, 0, 1, 0, 1, 0, 0)));
    tick(1, 1, 1); check("b2b c3", 32'(act), 32'(ov(0, 1, 1, 0, 0, 1, 0, 0)));
    tick(0, 1, 1); check("b2b c4", 32'(act), 32'(ov(0, 0, 0, 0, 0, 1, 1, 0)));
    tick(0, 1, 1); check("b2b c5", 32'(act), 32'(O_IDLE));
    tick(0, 1, 1); check("b2b c6", 32'(act), 32'(ov(1, 0, 0, 0, 0, 1, 0, 0)));
    tick(0, 1, 1); check("b2b c7", 32'(act), 32'(ov(0, 1, 0, 0, 0, 1, 0, 0)));
    tick(0, 1, 1); check("b2b c8", 32'(act), 32'(ov(0, 0, 0, 0, 1, 1, 0, 0)));
    tick(0, 0, 0); check("b2b c9", 32'(act), 32'(ov(0, 0, 0, 0, 0, 1, 1, 0)));
    tick(0, 0, 0); check("b2b c10", 32'(act), 32'(O_IDLE));

    // Reset in the middle of RD_WAIT: outputs clear at once, no done/err follows.
    tick(1, 0, 0); check("rst c0", 32'(act), 32'(O_IDLE));
    tick(1, 0, 0); check("rst c1", 32'(act), 32'(ov(1, 0, 0, 0, 0, 1, 0, 0)));
    tick(1, 0, 0); check("rst c2", 32'(act), 32'(ov(0, 0, 0, 1, 0, 1, 0, 0)));
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    check("rst async clear", 32'(act), 32'(O_IDLE));
    tick(1, 0, 1); check("rst held", 32'(act), 32'(O_IDLE));
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("rst release idle", 32'(act), 32'(O_IDLE));
    tick(1, 0, 1); check("rst first accept", 32'(act), 32'(ov(1, 0, 0, 0, 0, 1, 0, 0)));
    seen = -1;
    for (int t = 2; t < 12 && seen < 0; t++) begin
      tick(1, 0, 1);
      if (act.done || act.err) seen = t;
    end
    check("rst resume latency", 32'(seen), 32'd4);
    check("rst resume no err", 32'(act.err), 32'd0);
    tick(0, 0, 0); check("rst final idle", 32'(act), 32'(O_IDLE));

    // Randomised transactions against the model.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 2);
      rd  = (sel != 1);
      wr  = (sel != 0);
      if ($urandom_range(0, 3) == 0) n = TIMEOUT + $urandom_range(0, 2);
      else                           n = $urandom_range(0, TIMEOUT - 1);
      run_txn($sformatf("rand%0d", k), rd, wr, n, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
